// File: rtl/apb_cmd_pkg.sv
// Shared types and constants for the APB command master.
package apb_cmd_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned PROT_W = 3;
    localparam int unsigned ERR_W  = 2;
    localparam int unsigned ST_W   = 2;

    localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [ST_W-1:0] ST_SETUP  = 2'd1;
    localparam logic [ST_W-1:0] ST_ACCESS = 2'd2;
    localparam logic [ST_W-1:0] ST_RESP   = 2'd3;

    localparam logic [ERR_W-1:0] RSP_OK      = 2'b00;
    localparam logic [ERR_W-1:0] RSP_SLVERR  = 2'b01;
    localparam logic [ERR_W-1:0] RSP_TIMEOUT = 2'b10;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
        logic [PROT_W-1:0] prot;
    } apb_req_t;

    // Counter width able to hold values 0..limit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit <= 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating wait-cycle counter; expired_c flags that the current wait cycle is the LIMIT-th.
module apb_timeout_cnt
    import apb_cmd_pkg::*;
#(
    parameter int unsigned LIMIT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    localparam int unsigned CNT_W = cnt_width(LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign expired_c = en && (cnt_q >= CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB initiator: valid/ready command in, APB transfer, valid/ready response out.
module apb_cmd_master
    import apb_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic              PRESETn,
    input  logic              PCLK,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_write,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_strb,
    input  logic [PROT_W-1:0] cmd_prot,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ERR_W-1:0]  rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    output logic [STRB_W-1:0] PSTRB,
    output logic [PROT_W-1:0] PPROT,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PSLVERR
);

    logic [ST_W-1:0]   state_q,     state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [ERR_W-1:0]  rsp_err_q,   rsp_err_d;
    logic              psel_q,      psel_d;
    logic              penable_q,   penable_d;
    apb_req_t          req_q,       req_d;

    logic tmo_clr;
    logic tmo_en;
    logic timeout_c;

    // Wait-cycle watchdog; absent entirely when the timeout is disabled.
    if (TIMEOUT_CYCLES != 0) begin : g_tmo
        apb_timeout_cnt #(
            .LIMIT (TIMEOUT_CYCLES)
        ) u_tmo (
            .clk       (PCLK),
            .rst_n     (PRESETn),
            .clr       (tmo_clr),
            .en        (tmo_en),
            .expired_c (timeout_c)
        );
    end else begin : g_no_tmo
        assign timeout_c = 1'b0;
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        req_d       = req_q;
        tmo_clr     = 1'b1;
        tmo_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    req_d.addr  = cmd_addr;
                    req_d.write = cmd_write;
                    req_d.prot  = cmd_prot;
                    // Reads keep the previous PWDATA and drive no strobes.
                    if (cmd_write) begin
                        req_d.wdata = cmd_wdata;
                        req_d.strb  = cmd_strb;
                    end else begin
                        req_d.strb  = '0;
                    end
                    cmd_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    state_d     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                tmo_clr = 1'b0;
                if (PREADY) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = req_q.write ? '0 : PRDATA;
                    rsp_err_d   = PSLVERR ? RSP_SLVERR : RSP_OK;
                    state_d     = ST_RESP;
                end else begin
                    tmo_en = 1'b1;
                    // Abort drops the bus mid-transfer; recovery path for a hung slave.
                    if (timeout_c) begin
                        psel_d      = 1'b0;
                        penable_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_err_d   = RSP_TIMEOUT;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= RSP_OK;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            req_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            req_q       <= req_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = req_q.write;
    assign PADDR     = req_q.addr;
    assign PWDATA    = req_q.wdata;
    assign PSTRB     = req_q.strb;
    assign PPROT     = req_q.prot;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with an 8-cycle PREADY timeout.
module tb_apb_cmd_master;

    logic        PRESETn;
    logic        PCLK;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;

    int n_checks = 0;
    int n_errors = 0;

    apb_cmd_master #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .PRESETn   (PRESETn),
        .PCLK      (PCLK),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_write (cmd_write),
        .cmd_wdata (cmd_wdata),
        .cmd_strb  (cmd_strb),
        .cmd_prot  (cmd_prot),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PPROT     (PPROT),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA),
        .PSLVERR   (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Present a command and return just after the handshake edge (DUT in SETUP).
    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p);
        int n = 0;
        cmd_addr  = a;
        cmd_write = w;
        cmd_wdata = d;
        cmd_strb  = s;
        cmd_prot  = p;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 10) begin
            tick();
            n++;
        end
        if (n >= 10) check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] hold_rdata;

        // Reset with random inputs: every output low.
        PRESETn   = 1'b0;
        cmd_valid = 1'($urandom);
        cmd_addr  = $urandom;
        cmd_write = 1'($urandom);
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom);
        cmd_prot  = 3'($urandom);
        rsp_ready = 1'($urandom);
        PREADY    = 1'($urandom);
        PRDATA    = $urandom;
        PSLVERR   = 1'($urandom);
        tick();
        tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_psel", 32'(PSEL), 32'd0);
        check("rst_penable", 32'(PENABLE), 32'd0);
        check("rst_pwrite", 32'(PWRITE), 32'd0);
        check("rst_paddr", PADDR, 32'd0);
        check("rst_pwdata", PWDATA, 32'd0);
        check("rst_pstrb", 32'(PSTRB), 32'd0);
        check("rst_pprot", 32'(PPROT), 32'd0);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        PREADY    = 1'b1;
        PSLVERR   = 1'b0;
        PRDATA    = 32'h0;
        PRESETn   = 1'b1;
        check("rel_cmd_ready_pre", 32'(cmd_ready), 32'd0);
        tick();
        check("rel_cmd_ready", 32'(cmd_ready), 32'd1);

        // Zero-wait write.
        issue(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 3'b001);
        check("wr_setup_psel", 32'(PSEL), 32'd1);
        check("wr_setup_pen", 32'(PENABLE), 32'd0);
        check("wr_setup_paddr", PADDR, 32'h10);
        check("wr_setup_pwdata", PWDATA, 32'hDEADBEEF);
        check("wr_setup_pstrb", 32'(PSTRB), 32'hF);
        check("wr_setup_pwrite", 32'(PWRITE), 32'd1);
        check("wr_setup_pprot", 32'(PPROT), 32'd1);
        check("wr_setup_cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
        check("wr_acc_psel", 32'(PSEL), 32'd1);
        check("wr_acc_pen", 32'(PENABLE), 32'd1);
        check("wr_acc_paddr", PADDR, 32'h10);
        check("wr_acc_pwdata", PWDATA, 32'hDEADBEEF);
        tick();
        check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        check("wr_rsp_err", 32'(rsp_err), 32'd0);
        check("wr_rsp_rdata", rsp_rdata, 32'd0);
        check("wr_rsp_psel", 32'(PSEL), 32'd0);
        check("wr_rsp_pen", 32'(PENABLE), 32'd0);
        check("wr_idle_paddr", PADDR, 32'h10);
        tick();
        check("wr_done_valid", 32'(rsp_valid), 32'd0);
        check("wr_done_cmd_ready", 32'(cmd_ready), 32'd1);

        // Read with three wait states.
        PREADY = 1'b0;
        PRDATA = 32'h12345678;
        issue(32'h20, 1'b0, 32'h0BADF00D, 4'hF, 3'b010);
        check("rd_setup_pstrb", 32'(PSTRB), 32'd0);
        check("rd_setup_pwrite", 32'(PWRITE), 32'd0);
        check("rd_setup_pwdata", PWDATA, 32'hDEADBEEF);
        tick();
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("rd_acc%0d_psel", i), 32'(PSEL & PENABLE), 32'd1);
            check($sformatf("rd_acc%0d_pstrb", i), 32'(PSTRB), 32'd0);
            check($sformatf("rd_acc%0d_valid", i), 32'(rsp_valid), 32'd0);
            if (i == 4) PREADY = 1'b1;
            tick();
        end
        check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        check("rd_rsp_rdata", rsp_rdata, 32'h12345678);
        check("rd_rsp_err", 32'(rsp_err), 32'd0);
        tick();

        // Slave error on a zero-wait write.
        PSLVERR = 1'b1;
        issue(32'h30, 1'b1, 32'h5555AAAA, 4'h3, 3'b000);
        tick();
        tick();
        check("err_rsp_valid", 32'(rsp_valid), 32'd1);
        check("err_rsp_err", 32'(rsp_err), 32'd1);
        check("err_rsp_rdata", rsp_rdata, 32'd0);
        tick();
        // PSLVERR while PREADY=0 must not stick.
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        issue(32'h34, 1'b1, 32'h11112222, 4'hC, 3'b000);
        PSLVERR = 1'b1;
        tick();
        PSLVERR = 1'b0;
        PREADY  = 1'b1;
        tick();
        check("errign_rsp_valid", 32'(rsp_valid), 32'd1);
        check("errign_rsp_err", 32'(rsp_err), 32'd0);
        tick();

        // Timeout: PREADY stuck low, abort after 8 ACCESS cycles.
        PREADY = 1'b0;
        PRDATA = 32'hAAAA5555;
        issue(32'h40, 1'b0, 32'h0, 4'h0, 3'b000);
        tick();
        n = 0;
        while (PENABLE && n < 20) begin
            n++;
            tick();
        end
        check("tmo_access_cycles", 32'(n), 32'd8);
        check("tmo_rsp_valid", 32'(rsp_valid), 32'd1);
        check("tmo_rsp_err", 32'(rsp_err), 32'd2);
        check("tmo_rsp_rdata", rsp_rdata, 32'd0);
        check("tmo_psel", 32'(PSEL), 32'd0);
        tick();
        PREADY = 1'b1;
        issue(32'h44, 1'b1, 32'hFEEDFACE, 4'hF, 3'b000);
        tick();
        tick();
        check("post_tmo_valid", 32'(rsp_valid), 32'd1);
        check("post_tmo_err", 32'(rsp_err), 32'd0);
        tick();

        // Response backpressure; a waiting command must not be taken.
        rsp_ready = 1'b0;
        PRDATA    = 32'hCAFEF00D;
        issue(32'h50, 1'b0, 32'h0, 4'h0, 3'b000);
        tick();
        tick();
        PREADY    = 1'b0;
        cmd_addr  = 32'h60;
        cmd_write = 1'b0;
        cmd_strb  = 4'h0;
        cmd_prot  = 3'b000;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d_valid", i), 32'(rsp_valid), 32'd1);
            check($sformatf("bp%0d_rdata", i), rsp_rdata, 32'hCAFEF00D);
            check($sformatf("bp%0d_cmd_ready", i), 32'(cmd_ready), 32'd0);
            check($sformatf("bp%0d_paddr", i), PADDR, 32'h50);
            tick();
        end
        hold_rdata = rsp_rdata;
        check("bp_hold_rdata", hold_rdata, 32'hCAFEF00D);
        rsp_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(rsp_valid), 32'd0);
        check("bp_release_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        check("queued_paddr", PADDR, 32'h60);
        check("queued_psel", 32'(PSEL), 32'd1);
        tick();
        check("queued_acc_pen", 32'(PENABLE), 32'd1);

        // Asynchronous reset mid-ACCESS.
        #2;
        PRESETn = 1'b0;
        #1;
        check("arst_psel", 32'(PSEL), 32'd0);
        check("arst_penable", 32'(PENABLE), 32'd0);
        check("arst_cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
        PRESETn = 1'b1;
        tick();
        check("arst_rel_cmd_ready", 32'(cmd_ready), 32'd1);
        check("arst_rsp_lost", 32'(rsp_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
